pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline sequencer for the five-stage core. It arbitrates the single shared memory bus between instruction fetch (IF) and the data-memory stage (MEM), and merges the stall requests from IF, the ID operand-hazard detector, multi-cycle EX and MEM into one per-stage stall vector. It also generates the IF/ID flush for taken branches and keeps a bus-timeout error flag and a stall-cycle counter. It sits beside the pipeline registers; every stage register samples `o_stall` and the IF/ID register also samples `o_flushIfId`.

## Interface
- `TIMEOUT`, default 16: number of busy cycles without `i_busAck` before a transaction is aborted; legal range 2..255.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `i_ifReq` input 1: IF needs a bus transaction (instruction fetch); level, held until its done.
- `i_memReq` input 1: MEM needs a bus transaction (load/store); level, held until its done.
- `i_busAck` input 1: memory completes the granted transaction this cycle.
- `i_idStall` input 1: ID cannot issue; operand is produced by a load still in EX.
- `i_exBusy` input 1: multi-cycle EX operation is not finished.
- `i_branchTaken` input 1: ID resolved a taken branch/jump this cycle.
- `o_busReq` output 1: registered; a transaction is active on the bus.
- `o_busSel` output 1: registered; bus owner: 0 = IF, 1 = MEM.
- `o_ifDone` output 1: IF transaction completes this cycle.
- `o_memDone` output 1: MEM transaction completes this cycle.
- `o_stall` output 6: per-stage hold: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
- `o_flushIfId` output 1: IF/ID register loads a bubble next edge.
- `o_busErr` output 1: sticky; a transaction timed out.
- `o_stallCycles` output 32: saturating count of cycles with `o_stall[0]` = 1.

## Operation
- FSM states are IDLE, IF_BUSY and MEM_BUSY. One internal bit, `lastMem`, records the last owner (1 = MEM); it resets to 0.
- From IDLE:
  - Only `i_memReq` set: go to MEM_BUSY.
  - Only `i_ifReq` set: go to IF_BUSY.
  - Both set: go to MEM_BUSY if `lastMem` = 0, otherwise IF_BUSY. Both requesters therefore alternate.
  - Neither set: stay in IDLE.
- In the X_BUSY states:
  - `o_busReq` = 1 and `o_busSel` = (state == MEM_BUSY).
  - On `i_busAck`, return to IDLE and update `lastMem`.
  - The done strobes are combinational: `o_memDone` = `i_busAck` & MEM_BUSY, and `o_ifDone` = `i_busAck` & IF_BUSY.
  - `i_busAck` in IDLE is ignored.
- Timeout:
  - An 8-bit counter clears on entry to a busy state and increments each busy cycle.
  - When it reaches `TIMEOUT`-1 without `i_busAck`, the FSM returns to IDLE, `o_busErr` sets, no done strobe is issued and `lastMem` updates as if the transaction had completed.
  - The requester keeps requesting and is re-arbitrated.
- Wait terms: `memWait` = `i_memReq` & ~`o_memDone`, and `ifWait` = `i_ifReq` & ~`o_ifDone`.
- `o_stall` is combinational. The highest-priority active source wins:
  - `memWait` → 6'b011111.
  - `i_exBusy` → 6'b001111.
  - `i_idStall` → 6'b000111.
  - `ifWait` → 6'b000011.
  - Otherwise 0.
- `o_flushIfId` = `i_branchTaken` & ~`o_stall[2]`. A branch held in a stalled ID does not flush until ID advances.
- `o_stallCycles` increments on each edge where `o_stall[0]` = 1 and holds at 32'hFFFFFFFF.

## Timing
- Reset values: FSM in IDLE, `lastMem` = 0, timeout counter = 0, `o_busReq` = 0, `o_busSel` = 0, `o_busErr` = 0, `o_stallCycles` = 0. The combinational outputs follow from inputs with the FSM in IDLE.
- Arbitration latency: a request seen in IDLE at edge n gives `o_busReq` = 1 from edge n. The earliest ack is in the cycle after that, so the minimum transaction is 2 cycles of request including the grant cycle.
- Back-to-back transactions: after an ack the FSM spends one IDLE cycle before the next grant.
- Ack and timeout in the same cycle: the ack wins, so the done strobe fires and `o_busErr` is not set.
- Reset asserted mid-transaction: the FSM immediately returns to IDLE and `o_busReq` drops asynchronously. The memory must discard the in-flight access.
- While a requester is stalled its request stays asserted, so the grant is never lost.

## Test plan
- Reset, then `i_ifReq`=1 with the ack in the 2nd busy cycle → `o_busReq`=1, `o_busSel`=0 for 2 cycles; `o_ifDone` pulses once; `o_stall`=6'b000011 until that cycle.
- `i_ifReq` and `i_memReq` both held for 4 transactions, each acked after 1 cycle → grants go MEM, IF, MEM, IF; `o_stall`=6'b011111 while MEM waits.
- `i_exBusy`=1 and `i_idStall`=1 together for 3 cycles → `o_stall`=6'b001111; `o_stallCycles` = 3.
- `i_branchTaken`=1 with `i_idStall`=1, then `i_idStall`=0 → `o_flushIfId` stays 0 while stalled and is 1 in the release cycle.
- TIMEOUT=4, MEM request never acked → the FSM leaves MEM_BUSY after 4 busy cycles; `o_busErr`=1 and stays 1; after 1 IDLE cycle a new MEM grant is issued (MEM is re-granted if it requests alone).
- Assert `rst` in the middle of a MEM_BUSY transaction → `o_busReq`=0 immediately, `o_busErr`=0, `o_stallCycles`=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer. Arbitrates the shared memory bus between
// IF and MEM (alternating on conflict), merges stage stall requests into a
// per-stage hold vector, generates the IF/ID flush, tracks bus timeouts and
// counts stalled cycles.
module pipe_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_ifReq,
   input  logic        i_memReq,
   input  logic        i_busAck,
   input  logic        i_idStall,
   input  logic        i_exBusy,
   input  logic        i_branchTaken,
   output logic        o_busReq,
   output logic        o_busSel,
   output logic        o_ifDone,
   output logic        o_memDone,
   output logic [5:0]  o_stall,
   output logic        o_flushIfId,
   output logic        o_busErr,
   output logic [31:0] o_stallCycles
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } state_t;

   // Last busy cycle before a silent transaction is abandoned.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic        r_lastMem;
   logic [7:0]  r_toCnt;
   logic        r_busReq;
   logic        r_busSel;
   logic        r_busErr;
   logic [31:0] r_stallCycles;

   logic        w_busy;
   logic        w_timeout;
   logic        w_end;
   logic        w_memWait;
   logic        w_ifWait;
   logic [5:0]  w_stall;

   assign w_busy    = (r_state != IDLE);
   // An ack in the last allowed cycle wins over the timeout.
   assign w_timeout = w_busy && !i_busAck && (r_toCnt == TO_LAST);
   assign w_end     = w_busy && (i_busAck || w_timeout);

   // Next-state arbitration and done strobes.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      w_next    = r_state;
      o_ifDone  = 1'b0;
      o_memDone = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_memReq && i_ifReq)
               w_next = r_lastMem ? IF_BUSY : MEM_BUSY;
            else if (i_memReq)
               w_next = MEM_BUSY;
            else if (i_ifReq)
               w_next = IF_BUSY;
         end
         IF_BUSY: begin
            o_ifDone = i_busAck;
            if (w_end)
               w_next = IDLE;
         end
         MEM_BUSY: begin
            o_memDone = i_busAck;
            if (w_end)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // State register, owner history, timeout counter and registered bus outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_lastMem <= 1'b0;
         r_toCnt   <= 8'd0;
         r_busReq  <= 1'b0;
         r_busSel  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         r_state  <= w_next;
         r_busReq <= (w_next != IDLE);
         r_busSel <= (w_next == MEM_BUSY);
         if (w_end)
            r_lastMem <= (r_state == MEM_BUSY);
         // Counter sits at zero in IDLE, so it starts from zero on every grant.
         if (w_busy)
            r_toCnt <= r_toCnt + 8'd1;
         else
            r_toCnt <= 8'd0;
      end
   end

   // Sticky timeout error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_busErr <= 1'b0;
      else if (w_timeout)
         r_busErr <= 1'b1;
   end

   // Priority-merged stall vector: the deepest stalled stage freezes everything upstream.
   always_comb begin
      w_memWait = i_memReq && !o_memDone;
      w_ifWait  = i_ifReq && !o_ifDone;
      w_stall   = 6'b000000;
      if (w_memWait)
         w_stall = 6'b011111;
      else if (i_exBusy)
         w_stall = 6'b001111;
      else if (i_idStall)
         w_stall = 6'b000111;
      else if (w_ifWait)
         w_stall = 6'b000011;
   end

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stallCycles <= 32'd0;
      else if (w_stall[0] && (r_stallCycles != 32'hFFFF_FFFF))
         r_stallCycles <= r_stallCycles + 32'd1;
   end

   assign o_stall       = w_stall;
   // A branch sitting in a stalled ID must not flush until ID advances.
   assign o_flushIfId   = i_branchTaken && !w_stall[2];
   assign o_busReq      = r_busReq;
   assign o_busSel      = r_busSel;
   assign o_busErr      = r_busErr;
   assign o_stallCycles = r_stallCycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl. A vector table checks the
// combinational stall/flush merge with the FSM held in IDLE, then hand-written
// sequences cover arbitration, alternation, timeout and asynchronous reset.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_ifReq = 1'b0;
   logic        i_memReq = 1'b0;
   logic        i_busAck = 1'b0;
   logic        i_idStall = 1'b0;
   logic        i_exBusy = 1'b0;
   logic        i_branchTaken = 1'b0;
   logic        o_busReq;
   logic        o_busSel;
   logic        o_ifDone;
   logic        o_memDone;
   logic [5:0]  o_stall;
   logic        o_flushIfId;
   logic        o_busErr;
   logic [31:0] o_stallCycles;

   int errors = 0;
   int checks = 0;

   pipe_ctrl #(.TIMEOUT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_ifReq       (i_ifReq),
      .i_memReq      (i_memReq),
      .i_busAck      (i_busAck),
      .i_idStall     (i_idStall),
      .i_exBusy      (i_exBusy),
      .i_branchTaken (i_branchTaken),
      .o_busReq      (o_busReq),
      .o_busSel      (o_busSel),
      .o_ifDone      (o_ifDone),
      .o_memDone     (o_memDone),
      .o_stall       (o_stall),
      .o_flushIfId   (o_flushIfId),
      .o_busErr      (o_busErr),
      .o_stallCycles (o_stallCycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ifReq;
      logic       memReq;
      logic       exBusy;
      logic       idStall;
      logic       branch;
      logic [5:0] expStall;
      logic       expFlush;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      i_ifReq       = 1'b0;
      i_memReq      = 1'b0;
      i_busAck      = 1'b0;
      i_idStall     = 1'b0;
      i_exBusy      = 1'b0;
      i_branchTaken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] exp_stall;
      logic       exp_sel;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000011, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000111, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b001111, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'b011111, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000011, 1'b1};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000111, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b001111, 1'b0};
      vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b011111, 1'b0};

      // Reset values.
      #2;
      check("rst busReq", 32'(o_busReq), 32'd0);
      check("rst busSel", 32'(o_busSel), 32'd0);
      check("rst busErr", 32'(o_busErr), 32'd0);
      check("rst stallCycles", o_stallCycles, 32'd0);

      // Combinational merge with the FSM pinned in IDLE by reset.
      for (int i = 0; i < 10; i++) begin
         i_ifReq       = vecs[i].ifReq;
         i_memReq      = vecs[i].memReq;
         i_exBusy      = vecs[i].exBusy;
         i_idStall     = vecs[i].idStall;
         i_branchTaken = vecs[i].branch;
         #1;
         check($sformatf("vec%0d stall", i), 32'(o_stall), 32'(vecs[i].expStall));
         check($sformatf("vec%0d flush", i), 32'(o_flushIfId), 32'(vecs[i].expFlush));
         check($sformatf("vec%0d done", i), 32'({o_ifDone, o_memDone}), 32'd0);
         @(negedge clk);
      end
      check("table busReq", 32'(o_busReq), 32'd0);
      check("table stallCycles", o_stallCycles, 32'd0);

      // IF fetch acked in its 2nd busy cycle.
      do_reset();
      i_ifReq = 1'b1;
      #1;
      check("if c0 busReq", 32'(o_busReq), 32'd0);
      check("if c0 stall", 32'(o_stall), 32'b000011);
      next_cycle();
      check("if c1 busReq", 32'(o_busReq), 32'd1);
      check("if c1 busSel", 32'(o_busSel), 32'd0);
      check("if c1 ifDone", 32'(o_ifDone), 32'd0);
      check("if c1 stall", 32'(o_stall), 32'b000011);
      next_cycle();
      i_busAck = 1'b1;
      #1;
      check("if c2 busReq", 32'(o_busReq), 32'd1);
      check("if c2 busSel", 32'(o_busSel), 32'd0);
      check("if c2 ifDone", 32'(o_ifDone), 32'd1);
      check("if c2 stall", 32'(o_stall), 32'b000000);
      next_cycle();
      i_busAck = 1'b0;
      i_ifReq  = 1'b0;
      #1;
      check("if c3 busReq", 32'(o_busReq), 32'd0);
      check("if c3 ifDone", 32'(o_ifDone), 32'd0);
      check("if c3 stallCycles", o_stallCycles, 32'd2);

      // Both requesters held: grants alternate MEM, IF, MEM, IF.
      do_reset();
      i_ifReq  = 1'b1;
      i_memReq = 1'b1;
      for (int t = 0; t < 4; t++) begin
         exp_sel   = (t % 2 == 0);
         exp_stall = exp_sel ? 6'b000011 : 6'b011111;
         i_busAck  = 1'b0;
         #1;
         check($sformatf("alt%0d idle busReq", t), 32'(o_busReq), 32'd0);
         check($sformatf("alt%0d idle stall", t), 32'(o_stall), 32'b011111);
         next_cycle();
         i_busAck = 1'b1;
         #1;
         check($sformatf("alt%0d busReq", t), 32'(o_busReq), 32'd1);
         check($sformatf("alt%0d busSel", t), 32'(o_busSel), 32'(exp_sel));
         check($sformatf("alt%0d memDone", t), 32'(o_memDone), 32'(exp_sel));
         check($sformatf("alt%0d ifDone", t), 32'(o_ifDone), 32'(!exp_sel));
         check($sformatf("alt%0d stall", t), 32'(o_stall), 32'(exp_stall));
         next_cycle();
      end
      i_busAck = 1'b0;
      i_ifReq  = 1'b0;
      i_memReq = 1'b0;
      #1;
      check("alt end busReq", 32'(o_busReq), 32'd0);

      // EX busy and ID stall together: EX wins, three counted stall cycles.
      do_reset();
      i_exBusy  = 1'b1;
      i_idStall = 1'b1;
      for (int t = 0; t < 3; t++) begin
         #1;
         check($sformatf("ex%0d stall", t), 32'(o_stall), 32'b001111);
         next_cycle();
      end
      i_exBusy  = 1'b0;
      i_idStall = 1'b0;
      #1;
      check("ex release stall", 32'(o_stall), 32'b000000);
      check("ex stallCycles", o_stallCycles, 32'd3);

      // Branch held in a stalled ID flushes only on release.
      do_reset();
      i_branchTaken = 1'b1;
      i_idStall     = 1'b1;
      #1;
      check("br stalled0 flush", 32'(o_flushIfId), 32'd0);
      next_cycle();
      check("br stalled1 flush", 32'(o_flushIfId), 32'd0);
      next_cycle();
      i_idStall = 1'b0;
      #1;
      check("br release flush", 32'(o_flushIfId), 32'd1);
      next_cycle();
      i_branchTaken = 1'b0;

      // Ack arriving in the last allowed cycle beats the timeout.
      do_reset();
      i_memReq = 1'b1;
      next_cycle();
      repeat (3) next_cycle();
      i_busAck = 1'b1;
      #1;
      check("late ack busReq", 32'(o_busReq), 32'd1);
      check("late ack memDone", 32'(o_memDone), 32'd1);
      next_cycle();
      i_busAck = 1'b0;
      i_memReq = 1'b0;
      #1;
      check("late ack busErr", 32'(o_busErr), 32'd0);
      check("late ack idle", 32'(o_busReq), 32'd0);

      // MEM never acked: abandoned after 4 busy cycles, error sticks, re-granted.
      do_reset();
      i_memReq = 1'b1;
      next_cycle();
      for (int t = 0; t < 4; t++) begin
         check($sformatf("to busy%0d busReq", t), 32'(o_busReq), 32'd1);
         check($sformatf("to busy%0d memDone", t), 32'(o_memDone), 32'd0);
         check($sformatf("to busy%0d busErr", t), 32'(o_busErr), 32'd0);
         next_cycle();
      end
      check("to idle busReq", 32'(o_busReq), 32'd0);
      check("to idle busErr", 32'(o_busErr), 32'd1);
      next_cycle();
      check("to regrant busReq", 32'(o_busReq), 32'd1);
      check("to regrant busSel", 32'(o_busSel), 32'd1);
      i_busAck = 1'b1;
      #1;
      check("to regrant memDone", 32'(o_memDone), 32'd1);
      next_cycle();
      i_busAck = 1'b0;
      #1;
      check("to sticky busErr", 32'(o_busErr), 32'd1);
      check("to after idle", 32'(o_busReq), 32'd0);

      // Asynchronous reset in the middle of a MEM transaction.
      next_cycle();
      check("mid busReq", 32'(o_busReq), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid rst busReq", 32'(o_busReq), 32'd0);
      check("mid rst busErr", 32'(o_busErr), 32'd0);
      check("mid rst stallCycles", o_stallCycles, 32'd0);
      i_memReq = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
